// File: rtl/muldiv_pkg.sv
// Shared encodings and decode helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op != OP_MTHI) && (op != OP_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd};
    // modular difference is exact whenever ge holds, since the remainder fits WIDTH bits
    diff    = shifted[WIDTH-1:0] - opnd;
    if (is_div) begin
      next_hi = ge ? diff : shifted[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
//   state   | meaning
//   S_IDLE  | accepts mul/div (go RUN) or MTHI/MTLO (write in place)
//   S_RUN   | WIDTH radix-2 steps on operand magnitudes
//   S_FIXUP | sign correction, accumulate, commit HI/LO; Done next cycle
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Flush,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic               neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   opnd_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               sign_a, sign_b, accept, mt_write, div_q, div_zero, commit;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (div_q),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .opnd   (opnd_q),
    .next_hi(step_hi),
    .next_lo(step_lo)
  );

  always_comb begin
    sign_a   = is_signed_op(Op) & OpA[WIDTH-1];
    sign_b   = is_signed_op(Op) & OpB[WIDTH-1];
    mag_a    = sign_a ? -OpA : OpA;
    mag_b    = sign_b ? -OpB : OpB;
    accept   = (state_q == S_IDLE) && Start && !Flush && is_muldiv(Op);
    mt_write = (state_q == S_IDLE) && Start && !Flush && !is_muldiv(Op);
    div_q    = is_div_op(op_q);
    div_zero = div_q && (opnd_q == '0);
    commit   = (state_q == S_FIXUP) && !Flush && !div_zero;
    Busy     = (state_q != S_IDLE);
    Stall    = Busy && (Start || HiLoRead);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (Flush) state_d = S_IDLE;
               else if (cnt_q == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prod = {acc_hi_q, acc_lo_q};
    prod = neg_res_q ? -prod : prod;
    case (op_q)
      OP_MULT, OP_MULTU: res = prod;
      OP_MADD:           res = {HI, LO} + prod;
      OP_MSUB:           res = {HI, LO} - prod;
      OP_DIV, OP_DIVU:   res = {(neg_rem_q ? -acc_hi_q : acc_hi_q),
                                (neg_res_q ? -acc_lo_q : acc_lo_q)};
      default:           res = {HI, LO};
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      state_q   <= state_d;
      Done      <= (state_q == S_FIXUP) && !Flush;
      DivByZero <= (state_q == S_FIXUP) && !Flush && div_zero;
      if (accept) begin
        cnt_q     <= CW'(WIDTH - 1);
        op_q      <= Op;
        neg_res_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
        acc_hi_q  <= '0;
        // multiply iterates over the multiplier bits; divide shifts the dividend in
        opnd_q    <= is_div_op(Op) ? mag_b : mag_a;
        acc_lo_q  <= is_div_op(Op) ? mag_a : mag_b;
      end else if (state_q == S_RUN) begin
        cnt_q    <= cnt_q - CW'(1);
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
      end
      if (mt_write) begin
        if (Op == OP_MTHI) HI <= OpA;
        else               LO <= OpA;
      end
      if (commit) {HI, LO} <= res;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed bench for hilo_muldiv_unit against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush, hiloread;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        busy, stall, done, dbz;
  logic [31:0] hi, lo;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Op(op), .OpA(opa), .OpB(opb),
    .Flush(flush), .HiLoRead(hiloread), .Busy(busy), .Stall(stall),
    .Done(done), .DivByZero(dbz), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: an accepted op completes 33 edges later unless flushed or reset
  logic [31:0] m_hi = '0, m_lo = '0;
  int          m_rem = 0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  logic [2:0]  p_op;
  logic [31:0] p_a, p_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_commit();
    longint      sa, sb;
    logic [63:0] acc;
    acc = {m_hi, m_lo};
    sa  = longint'($signed(p_a));
    sb  = longint'($signed(p_b));
    case (p_op)
      3'd0: {m_hi, m_lo} = 64'(sa * sb);
      3'd1: {m_hi, m_lo} = {32'b0, p_a} * {32'b0, p_b};
      3'd2: if (p_b == 0) m_dbz = 1'b1;
            else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'd3: if (p_b == 0) m_dbz = 1'b1;
            else begin m_lo = p_a / p_b; m_hi = p_a % p_b; end
      3'd4: {m_hi, m_lo} = acc + 64'(sa * sb);
      3'd5: {m_hi, m_lo} = acc - 64'(sa * sb);
      default: ;
    endcase
    m_done = 1'b1;
  endtask

  task automatic tick();
    #1;
    if (!rst) chk("stall", {63'b0, stall}, {63'b0, (m_rem > 0) && (start || hiloread)});
    @(posedge clk);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) model_commit();
        end
      end else if (start && !flush) begin
        if (op < 3'd6) begin
          p_op = op; p_a = opa; p_b = opb; m_rem = 33;
        end else if (op == 3'd6) m_hi = opa;
        else m_lo = opa;
      end
    end
    #1;
    chk("hi",   {32'b0, hi}, {32'b0, m_hi});
    chk("lo",   {32'b0, lo}, {32'b0, m_lo});
    chk("busy", {63'b0, busy}, {63'b0, m_rem > 0});
    chk("done", {63'b0, done}, {63'b0, m_done});
    chk("dbz",  {63'b0, dbz},  {63'b0, m_dbz});
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; opa = a; opb = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bcnt);
    n    = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=33", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, bcnt;
    rst = 1'b1; start = 1'b0; flush = 1'b0; hiloread = 1'b0;
    op = '0; opa = '0; opb = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    chk("reset_hi", {32'b0, hi}, 64'h0);
    chk("reset_lo", {32'b0, lo}, 64'h0);
    chk("reset_busy", {63'b0, busy}, 64'h0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(n, bcnt);
    chk("mult_done_edge", 64'(n), 64'd33);
    chk("mult_busy_cycles", 64'(bcnt), 64'd33);
    chk("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'b0, lo}, 64'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bcnt);
    chk("multu_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'b0, lo}, 64'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, bcnt);
    chk("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bcnt);
    chk("divovf_lo", {32'b0, lo}, 64'h8000_0000);
    chk("divovf_hi", {32'b0, hi}, 64'h0);

    issue(3'd6, 32'hA, 32'h0);
    issue(3'd7, 32'hB, 32'h0);
    issue(3'd3, 32'd5, 32'd0);
    wait_done(n, bcnt);
    chk("div0_flag", {62'b0, dbz, done}, 64'h3);
    chk("div0_hi", {32'b0, hi}, 64'hA);
    chk("div0_lo", {32'b0, lo}, 64'hB);

    issue(3'd6, 32'h55, 32'h0);
    issue(3'd7, 32'h66, 32'h0);
    issue(3'd0, 32'd7, 32'd9);
    for (int i = 0; i < 10; i++) tick();
    hiloread = 1'b1;
    #1 chk("stall_read", {63'b0, stall}, 64'h1);
    tick();
    hiloread = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'h0);
    for (int i = 0; i < 40; i++) tick();
    chk("flush_hi", {32'b0, hi}, 64'h55);
    chk("flush_lo", {32'b0, lo}, 64'h66);

    issue(3'd0, 32'd1234, 32'd5678);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_hi", {32'b0, hi}, 64'h0);
    chk("rst_mid_lo", {32'b0, lo}, 64'h0);
    chk("rst_mid_busy", {63'b0, busy}, 64'h0);

    issue(3'd6, 32'h0, 32'h0);
    issue(3'd7, 32'd10, 32'h0);
    issue(3'd4, 32'd4, 32'hFFFF_FFFD);
    wait_done(n, bcnt);
    chk("madd_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("madd_lo", {32'b0, lo}, 64'hFFFF_FFFE);

    issue(3'd6, 32'h1234, 32'h0);
    chk("mthi_hi", {32'b0, hi}, 64'h1234);
    chk("mthi_busy", {63'b0, busy}, 64'h0);

    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 999) == 0);
      start    = ($urandom % 4) == 0;
      op       = 3'($urandom % 8);
      opa      = pick();
      opb      = (($urandom % 16) == 0) ? 32'h0 : pick();
      flush    = (m_rem > 0) && ($urandom_range(0, 59) == 0);
      hiloread = ($urandom % 3) == 0;
      tick();
    end
    rst = 1'b0; start = 1'b0; flush = 1'b0; hiloread = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
